// File: rtl/count_ctrl_pkg.sv
// Shared types for the count-rate controller: FSM states, time-base
// rate encodings and the prescaler period lookup.
package count_ctrl_pkg;

    localparam int unsigned PCNT_W = 30;

    typedef logic [PCNT_W-1:0] pcnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RATE_DIV1    = 2'd0,
        RATE_DIV10   = 2'd1,
        RATE_DIV100  = 2'd2,
        RATE_DIV1000 = 2'd3
    } rate_e;

    // Tick period in clk cycles; div_slow is an elaboration constant,
    // so each arm folds to a constant and this reduces to a 4:1 mux.
    function automatic pcnt_t rate_period(input int unsigned div_slow,
                                          input rate_e       rate);
        pcnt_t p;
        p = pcnt_t'(div_slow);
        unique case (rate)
            RATE_DIV1:    p = pcnt_t'(div_slow);
            RATE_DIV10:   p = pcnt_t'(div_slow / 10);
            RATE_DIV100:  p = pcnt_t'(div_slow / 100);
            RATE_DIV1000: p = pcnt_t'(div_slow / 1000);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/count_rate_ctrl_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick_en every `period` enabled
// cycles. Ports: clk, reset (sync, high), en (count), restart (pcnt=0),
// period (cycles per tick), tick_en (registered-count compare).
module tick_gen
    import count_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  restart,
    input  pcnt_t period,
    output logic  tick_en
);

    pcnt_t pcnt_q;
    pcnt_t pcnt_d;

    always_comb begin
        tick_en = en && (pcnt_q == period - pcnt_t'(1));
        pcnt_d  = pcnt_q;
        // restart wins so a rate change or run entry never lets pcnt
        // exceed the new period.
        if (restart) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = tick_en ? '0 : pcnt_q + pcnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/count_rate_ctrl.sv
// count_rate_ctrl: start/pause/clear FSM driving an up-counter from a
// decade-selectable tick. Inputs: clk, reset (sync, high), start, pause
// (level, edge-detected), clr (sync clear), rate_sel (period =
// DIV_SLOW/10^rate_sel). Outputs (registered): count, tick, busy, done,
// state. Optional COUNT_LOAD_EN adds load/load_val (load in IDLE/PAUSE).
module count_rate_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DIV_SLOW = 50000000,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_CNT  = 255,
    parameter int unsigned WRAP     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             clr,
    input  logic [1:0]       rate_sel,
`ifdef COUNT_LOAD_EN
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
`endif
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_prev_q, start_prev_d;
    logic             pause_prev_q, pause_prev_d;
    logic             start_rise_q, start_rise_d;
    logic             pause_rise_q, pause_rise_d;
    rate_e            rate_q, rate_d;

    logic             restart;
    logic             tick_en;
    pcnt_t            period;

`ifdef COUNT_LOAD_EN
    logic [CNT_W-1:0] load_lim;
    assign load_lim = (load_val > MAX_C) ? MAX_C : load_val;
`endif

    assign period = rate_period(DIV_SLOW, rate_q);

    tick_gen u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q == RUN),
        .restart (restart),
        .period  (period),
        .tick_en (tick_en)
    );

    always_comb begin
        start_prev_d = start;
        pause_prev_d = pause;
        start_rise_d = start & ~start_prev_q;
        pause_rise_d = pause & ~pause_prev_q;
        rate_d       = rate_e'(rate_sel);
        state_d      = state_q;
        count_d      = count_q;
        tick_d       = 1'b0;
        // A new rate restarts the prescaler on the following cycle.
        restart      = (rate_d != rate_q);

        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            restart = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
`ifdef COUNT_LOAD_EN
                    if (load) begin
                        count_d = load_lim;
                    end else
`endif
                    if (start_rise_q) begin
                        state_d = RUN;
                        restart = 1'b1;
                    end
                end
                RUN: begin
                    if (tick_en) begin
                        if (count_q != MAX_C) begin
                            count_d = count_q + ONE;
                            tick_d  = 1'b1;
                        end else if (WRAP != 0) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                    // Terminal DONE outranks a coincident pause.
                    if (pause_rise_q && state_d == RUN) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
`ifdef COUNT_LOAD_EN
                    if (load) begin
                        count_d = load_lim;
                    end else
`endif
                    if (start_rise_q || pause_rise_q) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (start_rise_q) begin
                        state_d = RUN;
                        count_d = '0;
                        restart = 1'b1;
                    end
                end
            endcase
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            start_rise_q <= 1'b0;
            pause_rise_q <= 1'b0;
            rate_q       <= RATE_DIV1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            start_rise_q <= start_rise_d;
            pause_rise_q <= pause_rise_d;
            rate_q       <= rate_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_count_rate_ctrl.sv
// Testbench for count_rate_ctrl with DIV_SLOW=1000 (periods 1000/100/10/1);
// dut0 uses WRAP=0, dut1 uses WRAP=1, both share stimulus.
module tb_count_rate_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] rate_sel = 2'd0;

    logic [7:0] count0, count1;
    logic       tick0, tick1;
    logic       busy0, busy1;
    logic       done0, done1;
    logic [1:0] state0, state1;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int at;
        int cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    count_rate_ctrl #(
        .DIV_SLOW (1000),
        .CNT_W    (8),
        .MAX_CNT  (255),
        .WRAP     (0)
    ) dut0 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .clr      (clr),
        .rate_sel (rate_sel),
`ifdef COUNT_LOAD_EN
        .load     (1'b0),
        .load_val (8'd0),
`endif
        .count    (count0),
        .tick     (tick0),
        .busy     (busy0),
        .done     (done0),
        .state    (state0)
    );

    count_rate_ctrl #(
        .DIV_SLOW (1000),
        .CNT_W    (8),
        .MAX_CNT  (255),
        .WRAP     (1)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .clr      (clr),
        .rate_sel (rate_sel),
`ifdef COUNT_LOAD_EN
        .load     (1'b0),
        .load_val (8'd0),
`endif
        .count    (count1),
        .tick     (tick1),
        .busy     (busy1),
        .done     (done1),
        .state    (state1)
    );

    // Scoreboard: every dut0 tick must match the next expected (cycle, count).
    always @(negedge clk) begin
        if (tick0 === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick cyc=%0d count=%0d required no tick",
                         cyc, count0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.at || count0 !== 8'(e.cnt)) begin
                    n_fail++;
                    $display("FAIL tick_sb got cyc=%0d count=%0d required cyc=%0d count=%0d",
                             cyc, count0, e.at, e.cnt);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input int at, input int cnt);
        exp_t e;
        e.at  = at;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Start pulse at this negedge; RUN is entered two edges later.
    task automatic run_start(output int e);
        start = 1'b1;
        e = cyc + 2;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic set_rate(input logic [1:0] r);
        rate_sel = r;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({count0, tick0, busy0, done0, state0} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut0 got %h required 0",
                     {count0, tick0, busy0, done0, state0});
        end
        n_chk++;
        if ({count1, tick1, busy1, done1, state1} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_dut1 got %h required 0",
                     {count1, tick1, busy1, done1, state1});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rate_basic;
        int e;
        set_rate(2'd2);
        run_start(e);
        for (int k = 1; k <= 5; k++) push(e + 10 * k, k);
        wait_until(e + 9);
        n_chk++;
        if (count0 !== 8'd0 || busy0 !== 1'b1 || state0 !== 2'd1) begin
            n_fail++;
            $display("FAIL run_entry got count=%0d busy=%b state=%0d required 0 1 1",
                     count0, busy0, state0);
        end
        wait_until(e + 50);
        n_chk++;
        if (count0 !== 8'd5) begin
            n_fail++;
            $display("FAIL count_after_50 got %0d required 5", count0);
        end
        do_clr();
    endtask

    task automatic test_terminal_wrap;
        int e;
        set_rate(2'd3);
        run_start(e);
        for (int k = 1; k <= 255; k++) push(e + k, k);
        wait_until(e + 255);
        n_chk++;
        if (count0 !== 8'd255 || state0 !== 2'd1) begin
            n_fail++;
            $display("FAIL at_max got count=%0d state=%0d required 255 1",
                     count0, state0);
        end
        wait_until(e + 256);
        n_chk++;
        if ({count0, tick0, busy0, done0, state0} !== {8'd255, 1'b0, 1'b0, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL done_stop got count=%0d tick=%b busy=%b done=%b state=%0d required 255 0 0 1 3",
                     count0, tick0, busy0, done0, state0);
        end
        n_chk++;
        if ({count1, tick1, busy1, state1} !== {8'd0, 1'b1, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL wrap got count=%0d tick=%b busy=%b state=%0d required 0 1 1 1",
                     count1, tick1, busy1, state1);
        end
    endtask

    task automatic test_done_restart;
        int e;
        run_start(e);
        n_chk++;
        if (done0 !== 1'b1 || count0 !== 8'd255) begin
            n_fail++;
            $display("FAIL done_hold got done=%b count=%0d required 1 255",
                     done0, count0);
        end
        wait_until(e);
        n_chk++;
        if (count0 !== 8'd0 || state0 !== 2'd1 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_restart got count=%0d state=%0d done=%b required 0 1 0",
                     count0, state0, done0);
        end
        // clr lands on a tick_en cycle (period 1) and must suppress it.
        do_clr();
        n_chk++;
        if ({count0, tick0, state0} !== {8'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL clr_rate3 got count=%0d tick=%b state=%0d required 0 0 0",
                     count0, tick0, state0);
        end
    endtask

    task automatic test_pause;
        int e;
        int e2;
        set_rate(2'd2);
        run_start(e);
        push(e + 10, 1);
        wait_until(e + 14);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        wait_until(e + 16);
        n_chk++;
        if (state0 !== 2'd2 || busy0 !== 1'b0 || count0 !== 8'd1) begin
            n_fail++;
            $display("FAIL pause_enter got state=%0d busy=%b count=%0d required 2 0 1",
                     state0, busy0, count0);
        end
        wait_until(e + 36);
        n_chk++;
        if (state0 !== 2'd2 || count0 !== 8'd1) begin
            n_fail++;
            $display("FAIL pause_hold got state=%0d count=%0d required 2 1",
                     state0, count0);
        end
        run_start(e2);
        push(e2 + 4, 2);
        push(e2 + 14, 3);
        wait_until(e2);
        n_chk++;
        if (state0 !== 2'd1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL resume got state=%0d busy=%b required 1 1", state0, busy0);
        end
        wait_until(e2 + 14);
        do_clr();
    endtask

    task automatic test_pause_tick_same_cycle;
        int e;
        run_start(e);
        push(e + 10, 1);
        wait_until(e + 8);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        wait_until(e + 10);
        n_chk++;
        if (state0 !== 2'd2 || count0 !== 8'd1) begin
            n_fail++;
            $display("FAIL tick_and_pause got state=%0d count=%0d required 2 1",
                     state0, count0);
        end
        do_clr();
    endtask

    task automatic test_clr_tick;
        int e;
        run_start(e);
        for (int k = 1; k <= 7; k++) push(e + 10 * k, k);
        wait_until(e + 79);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_chk++;
        if ({count0, tick0, busy0, state0} !== {8'd0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL clr_on_tick got count=%0d tick=%b busy=%b state=%0d required 0 0 0 0",
                     count0, tick0, busy0, state0);
        end
        @(negedge clk);
    endtask

    task automatic test_rate_change;
        int e;
        set_rate(2'd1);
        run_start(e);
        wait_until(e + 40);
        rate_sel = 2'd2;
        push(e + 51, 1);
        push(e + 61, 2);
        wait_until(e + 62);
        n_chk++;
        if (count0 !== 8'd2 || state0 !== 2'd1) begin
            n_fail++;
            $display("FAIL rate_change got count=%0d state=%0d required 2 1",
                     count0, state0);
        end
        do_clr();
    endtask

    initial begin
        test_reset();
        test_rate_basic();
        test_terminal_wrap();
        test_done_restart();
        test_pause();
        test_pause_tick_same_cycle();
        test_clr_tick();
        test_rate_change();
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_ticks got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_rate_ctrl.md
Name: count_rate_ctrl

Overview:
- Controller that sequences the 8-bit up-counter datapath from a selectable time base.
- Replaces free-running square-wave dividers with single-cycle enable ticks at one of four decade rates.
- Runs a start/pause/clear FSM and drives the count value, status and LED-rate output.
- Sits between board buttons/switches and the counter/display logic; one clock domain.

Parameters:
- DIV_SLOW, 50000000, clk cycles per tick at rate_sel=0; must be divisible by 1000.
- CNT_W, 8, counter width.
- MAX_CNT, 255, terminal count (≤ 2^CNT_W−1).
- WRAP, 0; 1 = wrap to 0 after MAX_CNT, 0 = stop in DONE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; run request, edge-detected internally
- pause  in  1  level; pause request, edge-detected internally
- clr  in  1  level; synchronous clear of count and FSM
- rate_sel  in  2  tick period = DIV_SLOW / 10^rate_sel cycles
- count  out  CNT_W  current count
- tick  out  1  one-cycle pulse when count increments
- busy  out  1  high in RUN
- done  out  1  high in DONE
- state  out  2  FSM state encoding

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: count=0, tick=0, busy=0, done=0, state=IDLE, prescaler=0, edge registers=0.
- Edge detection: start_rise and pause_rise are 1-cycle pulses, registered. There is 1 cycle of latency from the input going high to the FSM acting.
- Prescaler: counter pcnt (30 bits). It runs only in RUN. When pcnt == period−1, it wraps to 0 and asserts an internal tick_en.
- Period values: rate_sel=0 → DIV_SLOW, 1 → /10, 2 → /100, 3 → /1000.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - IDLE: start_rise → RUN, with pcnt=0.
  - RUN: on tick_en, count+1 and tick=1 in the same cycle as the update. pause_rise → PAUSE; pcnt is held, not cleared.
  - RUN at terminal: on tick_en with count==MAX_CNT, WRAP=1 gives count=0 and stays in RUN. WRAP=0 keeps count=MAX_CNT, moves to DONE, and no tick is issued.
  - PAUSE: start_rise or pause_rise → RUN, resuming pcnt from its held value.
  - DONE: start_rise → RUN with count=0 and pcnt=0.
- Priority: reset > clr > tick_en > pause_rise > start_rise.
  - clr in any state → IDLE, count=0, pcnt=0, and the tick is suppressed.
  - If tick_en and pause_rise occur in the same cycle, the increment happens and the FSM goes to PAUSE.
- rate_sel change during RUN:
  - Sampled every cycle. A change restarts pcnt at 0 on the next cycle.
  - A tick_en in the change cycle still applies.
  - The new period takes effect from the restart.
- Outputs are registered. busy = (state==RUN); done = (state==DONE).
- Arithmetic: count is unsigned, modulo 2^CNT_W; pcnt never exceeds period−1.

Optional Feature:
- Macro: COUNT_LOAD_EN.
- Defined: adds ports load (in, 1) and load_val (in, CNT_W). A load pulse in IDLE or PAUSE sets count=min(load_val, MAX_CNT) next cycle and leaves state unchanged. Load is ignored in RUN and DONE. Priority is below clr.
- Undefined: no load ports; count changes only via tick or clr.

Decomposition:
- Shared package count_ctrl_pkg:
  - state enum IDLE/RUN/PAUSE/DONE (2-bit);
  - rate_sel encodings;
  - function returning period for a given DIV_SLOW and rate.
- One sub-module, tick_gen: holds pcnt and compares against the period. Its inputs are clk, reset, en, restart and period; its output is tick_en.

Test Plan:
All scenarios use DIV_SLOW=1000, giving periods 1000/100/10/1.
- Reset, then start with rate_sel=2: first tick 10 cycles after RUN entry, then every 10 cycles; count=5 after 50 cycles.
- rate_sel=3, WRAP=0: count reaches 255 at 255 cycles. Next tick_en → DONE, done=1, count stays 255, no tick. Start → count=0, RUN.
- WRAP=1, rate_sel=3: count goes 255 → 0 with tick=1 and busy held high.
- Pause after pcnt=6 at rate_sel=2: hold 20 cycles with count frozen. Resume → next tick 4 cycles later.
- clr asserted in the same cycle as tick_en with count=7: count=0, no tick, state=IDLE.
- rate_sel changes 1→2 mid-period at pcnt=40: next tick 10 cycles after the restart, not 60.
